pe_feed_scheduler: RTL and testbench
====================================

PE_FEED_SCHEDULER -- requirements
Module: pe_feed_scheduler

Interface
REQ-001 SHALL have parameter DataInWidth, default 8, width of weight/input/bias operands.
REQ-002 SHALL have parameter DataOutWidth, default 16, width of PE result and accumulated job result.
REQ-003 SHALL have parameter MaxOutstanding, default 4, PE buffer depth; issued-minus-retired limit per channel.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk input 1 rising-edge clock; rst_n input 1 asynchronous active-low reset.
REQ-005 SHALL have ports cmd_valid in 1, cmd_rdy out 1, cmd_len in 8 (job element count K), cmd_bias in DataInWidth.
REQ-006 SHALL have ports src_w_valid in 1, src_w_rdy out 1, src_w_data in DataInWidth (weight stream); src_i_valid/src_i_rdy/src_i_data likewise (input stream).
REQ-007 SHALL have ports pe_w_valid out 1, pe_w_rdy in 1, pe_w_data out DataInWidth; pe_i_valid/pe_i_rdy/pe_i_data likewise (to PE W/I inputs).
REQ-008 SHALL have ports pe_o_nop out 1, pe_o_rdy in 1, pe_o_data out DataInWidth (PE partial-sum input).
REQ-009 SHALL have ports pe_nop_out in 1, pe_data_out in DataOutWidth (PE MAC result; pe_nop_out=0 marks a valid result).
REQ-010 SHALL have ports res_valid out 1, res_rdy in 1, res_data out DataOutWidth, busy out 1, err out 1.

Function
REQ-011 SHALL implement FSM IDLE, RUN, DONE; reset state IDLE.
REQ-012 IDLE: cmd_rdy=1; cmd_valid=1 latches cmd_len into K, cmd_bias into bias, clears counters/accumulator; K>0 -> RUN, K=0 -> DONE with res_data=0.
REQ-013 SHALL keep per-channel issue counters w_cnt, i_cnt, o_cnt (0..K) and retire counter r_cnt (0..K).
REQ-014 Channel X (W, I, O) gate_X SHALL be 1 only in RUN with X_cnt<K and X_cnt-r_cnt<MaxOutstanding.
REQ-015 W/I SHALL pass through combinationally: pe_X_valid=src_X_valid&gate_X, src_X_rdy=pe_X_rdy&gate_X, pe_X_data=src_X_data; X_cnt increments on pe_X_valid&pe_X_rdy; zero added latency.
REQ-016 O channel: pe_o_nop=gate_O; pe_o_data=bias when o_cnt=0, else 0; o_cnt increments on pe_o_nop&pe_o_rdy.
REQ-017 In RUN, pe_nop_out=0 SHALL retire one result: r_cnt+1, acc<=acc+pe_data_out modulo 2^DataOutWidth; no backpressure to PE.
REQ-018 Retire making r_cnt=K SHALL move RUN->DONE next cycle; res_data=acc including that final result.
REQ-019 DONE: res_valid=1, res_data held stable; res_valid&res_rdy -> IDLE next cycle; res_valid low otherwise.
REQ-020 Issue and retire in same cycle on one channel SHALL net zero outstanding change; the limit uses pre-update counts.
REQ-021 busy=1 in RUN or DONE; cmd_rdy=0 outside IDLE.
REQ-022 pe_nop_out=0 in IDLE/DONE, or in RUN with r_cnt=K or r_cnt>=min(w_cnt,i_cnt,o_cnt), SHALL set err sticky; result ignored; acc/r_cnt unchanged.
REQ-023 K=255 SHALL work without counter overflow (counters 8 bits wide, saturating at K).

Reset
REQ-024 rst_n low SHALL immediately force IDLE, all counters/acc/bias=0, err=0, res_valid=0, busy=0, cmd_rdy=1 after release, all pe_*_valid/pe_o_nop=0, src_*_rdy=0.
REQ-025 Reset asserted mid-RUN SHALL discard the job; in-flight PE results after release SHALL set err.

Verification
REQ-026 K=3, bias=5, W={1,2,3}, I={4,5,6}, PE model always ready, results 9,10,18 -> res_data=37, res_valid after third retire+1 cycle, exactly 3 handshakes per channel.
REQ-027 K=8, pe_w_rdy held 1, PE results withheld -> exactly 4 W handshakes, then pe_w_valid=0 until one retire, then one more issue.
REQ-028 K=0 -> DONE next cycle, res_data=0, no PE handshakes; res_rdy=0 for 5 cycles -> res_valid and res_data stable.
REQ-029 pe_nop_out=0 while IDLE -> err=1 and stays 1; acc unaffected on next job.
REQ-030 rst_n low during RUN after 2 of 5 elements -> all outputs at reset values asynchronously; new K=1 job completes correctly.
REQ-031 Results summing to 0x1FFFE with DataOutWidth=16 -> res_data=0xFFFE (wrap).

Source files
------------

// File: rtl/pe_feed_scheduler_if.sv
// Handshake bundle between the PE feed scheduler and its command, source, PE and result neighbours.
// The master modport is the scheduler's view and the slave modport is the environment's view.
interface pe_feed_scheduler_if #(
  parameter int DataInWidth  = 8,
  parameter int DataOutWidth = 16
);
  logic                    cmd_valid;
  logic                    cmd_rdy;
  logic [7:0]              cmd_len;
  logic [DataInWidth-1:0]  cmd_bias;

  logic                    src_w_valid;
  logic                    src_w_rdy;
  logic [DataInWidth-1:0]  src_w_data;
  logic                    src_i_valid;
  logic                    src_i_rdy;
  logic [DataInWidth-1:0]  src_i_data;

  logic                    pe_w_valid;
  logic                    pe_w_rdy;
  logic [DataInWidth-1:0]  pe_w_data;
  logic                    pe_i_valid;
  logic                    pe_i_rdy;
  logic [DataInWidth-1:0]  pe_i_data;
  logic                    pe_o_nop;
  logic                    pe_o_rdy;
  logic [DataInWidth-1:0]  pe_o_data;

  logic                    pe_nop_out;
  logic [DataOutWidth-1:0] pe_data_out;

  logic                    res_valid;
  logic                    res_rdy;
  logic [DataOutWidth-1:0] res_data;
  logic                    busy;
  logic                    err;

  modport master (
    input  cmd_valid, cmd_len, cmd_bias,
    output cmd_rdy,
    input  src_w_valid, src_w_data, src_i_valid, src_i_data,
    output src_w_rdy, src_i_rdy,
    output pe_w_valid, pe_w_data, pe_i_valid, pe_i_data, pe_o_nop, pe_o_data,
    input  pe_w_rdy, pe_i_rdy, pe_o_rdy,
    input  pe_nop_out, pe_data_out,
    output res_valid, res_data, busy, err,
    input  res_rdy
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_bias,
    input  cmd_rdy,
    output src_w_valid, src_w_data, src_i_valid, src_i_data,
    input  src_w_rdy, src_i_rdy,
    input  pe_w_valid, pe_w_data, pe_i_valid, pe_i_data, pe_o_nop, pe_o_data,
    output pe_w_rdy, pe_i_rdy, pe_o_rdy,
    output pe_nop_out, pe_data_out,
    input  res_valid, res_data, busy, err,
    output res_rdy
  );
endinterface

// File: rtl/pe_feed_scheduler.sv
// Feeds K weight/input/partial-sum triples to a PE, bounds in-flight work per channel,
// and accumulates the K returned MAC results into one job result.
module pe_feed_scheduler #(
  parameter int DataInWidth    = 8,
  parameter int DataOutWidth   = 16,
  parameter int MaxOutstanding = 4
) (
  input  logic clk,
  input  logic rst_n,
  pe_feed_scheduler_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  localparam logic [8:0] OutLimit = 9'(MaxOutstanding);

  stateT                   state, nextState;
  logic [7:0]              jobLen, wCnt, iCnt, oCnt, rCnt;
  logic [DataInWidth-1:0]  bias;
  logic [DataOutWidth-1:0] acc;
  logic                    errFlag;
  logic                    gateW, gateI, gateO;
  logic                    wFire, iFire, oFire, peResult, retire;

  function automatic logic underLimit(input logic [7:0] issued, input logic [7:0] retired);
    return {1'b0, 8'(issued - retired)} < OutLimit;
  endfunction

  function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  assign gateW = (state == RUN) && (wCnt < jobLen) && underLimit(wCnt, rCnt);
  assign gateI = (state == RUN) && (iCnt < jobLen) && underLimit(iCnt, rCnt);
  assign gateO = (state == RUN) && (oCnt < jobLen) && underLimit(oCnt, rCnt);

  // W and I are pure pass-through; the gates only open or close the path.
  assign bus.pe_w_valid = bus.src_w_valid & gateW;
  assign bus.src_w_rdy  = bus.pe_w_rdy & gateW;
  assign bus.pe_w_data  = bus.src_w_data;
  assign bus.pe_i_valid = bus.src_i_valid & gateI;
  assign bus.src_i_rdy  = bus.pe_i_rdy & gateI;
  assign bus.pe_i_data  = bus.src_i_data;
  assign bus.pe_o_nop   = gateO;
  assign bus.pe_o_data  = (oCnt == 8'd0) ? bias : '0;

  assign wFire = bus.src_w_valid & bus.pe_w_rdy & gateW;
  assign iFire = bus.src_i_valid & bus.pe_i_rdy & gateI;
  assign oFire = gateO & bus.pe_o_rdy;

  // A result is only legal in RUN for an element whose three operands were all issued.
  assign peResult = ~bus.pe_nop_out;
  assign retire   = peResult && (state == RUN) && (rCnt < jobLen) &&
                    (rCnt < min3(wCnt, iCnt, oCnt));

  assign bus.res_data = acc;
  assign bus.err      = errFlag;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    nextState     = state;
    bus.cmd_rdy   = 1'b0;
    bus.res_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      IDLE: begin
        bus.cmd_rdy = 1'b1;
        bus.busy    = 1'b0;
        if (bus.cmd_valid) nextState = (bus.cmd_len == 8'd0) ? DONE : RUN;
      end
      RUN: begin
        if (retire && (rCnt + 8'd1 == jobLen)) nextState = DONE;
      end
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_rdy) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jobLen  <= '0;
      bias    <= '0;
      wCnt    <= '0;
      iCnt    <= '0;
      oCnt    <= '0;
      rCnt    <= '0;
      acc     <= '0;
      errFlag <= 1'b0;
    end else begin
      if (state == IDLE && bus.cmd_valid) begin
        jobLen <= bus.cmd_len;
        bias   <= bus.cmd_bias;
        wCnt   <= '0;
        iCnt   <= '0;
        oCnt   <= '0;
        rCnt   <= '0;
        acc    <= '0;
      end else begin
        if (wFire) wCnt <= wCnt + 8'd1;
        if (iFire) iCnt <= iCnt + 8'd1;
        if (oFire) oCnt <= oCnt + 8'd1;
        if (retire) begin
          rCnt <= rCnt + 8'd1;
          acc  <= acc + bus.pe_data_out;
        end
      end
      if (peResult && !retire) errFlag <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pe_feed_scheduler.sv
// Scoreboarded bench: jobs push their expected sum, a PE/source model drives the DUT,
// and a monitor compares each accepted result against the queue.
module tb_pe_feed_scheduler;
  localparam int DIW    = 8;
  localparam int DOW    = 16;
  localparam int MaxOut = 4;
  localparam int Big    = 1 << 30;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_feed_scheduler_if #(.DataInWidth(DIW), .DataOutWidth(DOW)) bus ();

  pe_feed_scheduler #(
    .DataInWidth(DIW), .DataOutWidth(DOW), .MaxOutstanding(MaxOut)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  wSrc[$], iSrc[$], jobW[$], jobI[$];
  logic [7:0]  peWq[$], peIq[$], peOq[$];
  logic [15:0] peRes[$];
  logic [15:0] expQ[$];
  logic [15:0] t1, t2, t3, expVal;

  bit rndRdy = 0, rndValid = 0, rndDelay = 0, resHold = 0, stray = 0;
  int peBudget = Big;
  int cycle = 0, lastRetireCyc = -10, resRiseCyc = -10;
  int wHsTotal = 0, iHsTotal = 0, oHsTotal = 0;
  bit wHs = 0, iHs = 0, oHs = 0, prevResValid = 0;
  logic [7:0] wHsData, iHsData, oHsData;
  int w0, i0, o0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Sources, PE and result sink. Handshakes seen just after the falling edge
  // complete on the following rising edge and are applied at the next falling edge.
  initial begin
    bus.src_w_valid = 1'b0; bus.src_w_data = '0;
    bus.src_i_valid = 1'b0; bus.src_i_data = '0;
    bus.pe_w_rdy = 1'b0; bus.pe_i_rdy = 1'b0; bus.pe_o_rdy = 1'b0;
    bus.pe_nop_out = 1'b1; bus.pe_data_out = '0;
    bus.res_rdy = 1'b0;
    forever begin
      @(negedge clk);
      cycle++;
      if (!rst_n) begin
        wHs = 0; iHs = 0; oHs = 0; prevResValid = 0;
        wSrc.delete(); iSrc.delete();
        peWq.delete(); peIq.delete(); peOq.delete(); peRes.delete();
        bus.src_w_valid = 1'b0; bus.src_i_valid = 1'b0;
        bus.pe_w_rdy = 1'b0; bus.pe_i_rdy = 1'b0; bus.pe_o_rdy = 1'b0;
        bus.pe_nop_out = 1'b1; bus.res_rdy = 1'b0;
        continue;
      end
      if (wHs) begin
        if (wSrc.size() > 0) void'(wSrc.pop_front());
        peWq.push_back(wHsData); wHsTotal++;
      end
      if (iHs) begin
        if (iSrc.size() > 0) void'(iSrc.pop_front());
        peIq.push_back(iHsData); iHsTotal++;
      end
      if (oHs) begin
        peOq.push_back(oHsData); oHsTotal++;
      end
      while (peWq.size() > 0 && peIq.size() > 0 && peOq.size() > 0) begin
        t1 = 16'(peWq.pop_front());
        t2 = 16'(peIq.pop_front());
        t3 = 16'(peOq.pop_front());
        peRes.push_back(t1 * t2 + t3);
      end
      if (stray) begin
        bus.pe_nop_out = 1'b0; bus.pe_data_out = 16'h5555; stray = 0;
      end else if (peRes.size() > 0 && peBudget > 0 && (!rndDelay || $urandom_range(0, 2) != 0)) begin
        bus.pe_nop_out = 1'b0; bus.pe_data_out = peRes.pop_front();
        peBudget--; lastRetireCyc = cycle;
      end else begin
        bus.pe_nop_out = 1'b1; bus.pe_data_out = 16'($urandom);
      end
      bus.src_w_valid = (wSrc.size() > 0) && (!rndValid || $urandom_range(0, 3) != 0);
      bus.src_w_data  = (wSrc.size() > 0) ? wSrc[0] : 8'($urandom);
      bus.src_i_valid = (iSrc.size() > 0) && (!rndValid || $urandom_range(0, 3) != 0);
      bus.src_i_data  = (iSrc.size() > 0) ? iSrc[0] : 8'($urandom);
      bus.pe_w_rdy = !rndRdy || $urandom_range(0, 3) != 0;
      bus.pe_i_rdy = !rndRdy || $urandom_range(0, 3) != 0;
      bus.pe_o_rdy = !rndRdy || $urandom_range(0, 3) != 0;
      bus.res_rdy  = !resHold && (!rndRdy || $urandom_range(0, 1) != 0);
      #1;
      wHs = bus.pe_w_valid && bus.pe_w_rdy; wHsData = bus.pe_w_data;
      iHs = bus.pe_i_valid && bus.pe_i_rdy; iHsData = bus.pe_i_data;
      oHs = bus.pe_o_nop && bus.pe_o_rdy;   oHsData = bus.pe_o_data;
      if (bus.res_valid && !prevResValid) resRiseCyc = cycle;
      prevResValid = bus.res_valid;
    end
  end

  // Result monitor: pops the oldest expected sum on every result handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.res_valid && bus.res_rdy) begin
        if (expQ.size() == 0) begin
          tests++; fails++;
          $display("FAIL res_unexpected: got 0x%0h with no job outstanding", bus.res_data);
        end else begin
          expVal = expQ.pop_front();
          check("res_data", 32'(bus.res_data), 32'(expVal));
        end
      end
    end
  end

  task automatic make_job(input int k);
    jobW.delete(); jobI.delete();
    for (int n = 0; n < k; n++) begin
      jobW.push_back(8'($urandom));
      jobI.push_back(8'($urandom));
    end
  endtask

  // Expected result: bias plus the dot product, wrapped to the result width; an empty job yields 0.
  task automatic issue_job(input logic [7:0] b);
    int e;
    e = (jobW.size() == 0) ? 0 : int'(b);
    for (int n = 0; n < jobW.size(); n++) e = (e + jobW[n] * jobI[n]) & 32'hFFFF;
    expQ.push_back(16'(e));
    wSrc = jobW;
    iSrc = jobI;
    @(negedge clk);
    bus.cmd_len = 8'(jobW.size()); bus.cmd_bias = b; bus.cmd_valid = 1'b1;
    for (int t = 0; ; t++) begin
      #1;
      if (bus.cmd_rdy) break;
      if (t > 50) begin fail_now("cmd_accept"); break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #3;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    expQ.delete();
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (expQ.size() > 0 && t < budget) begin
      @(negedge clk); #3; t++;
    end
    if (expQ.size() > 0) begin
      fail_now("job_done");
      do_reset();
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_bias = '0;
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("rst_cmd_rdy",   bus.cmd_rdy, 1);
    check("rst_busy",      bus.busy, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_err",       bus.err, 0);
    check("rst_pe_o_nop",  bus.pe_o_nop, 0);
    check("rst_src_w_rdy", bus.src_w_rdy, 0);

    // Small job with known results 9, 10, 18.
    jobW = '{8'd1, 8'd2, 8'd3};
    jobI = '{8'd4, 8'd5, 8'd6};
    w0 = wHsTotal; i0 = iHsTotal; o0 = oHsTotal;
    issue_job(8'd5);
    wait_done(200);
    check("k3_w_hs", wHsTotal - w0, 3);
    check("k3_i_hs", iHsTotal - i0, 3);
    check("k3_o_hs", oHsTotal - o0, 3);
    check("k3_res_latency", resRiseCyc - lastRetireCyc, 1);

    // Outstanding limit with results withheld.
    peBudget = 0;
    make_job(8);
    w0 = wHsTotal;
    issue_job(8'($urandom));
    repeat (20) @(negedge clk);
    #3;
    check("k8_w_hs_capped", wHsTotal - w0, MaxOut);
    check("k8_w_valid_stalled", bus.pe_w_valid, 0);
    peBudget = 1;
    repeat (10) @(negedge clk);
    #3;
    check("k8_w_hs_after_retire", wHsTotal - w0, MaxOut + 1);
    peBudget = Big;
    wait_done(300);
    check("k8_w_hs_total", wHsTotal - w0, 8);

    // Empty job held in DONE by res_rdy=0.
    resHold = 1;
    make_job(0);
    w0 = wHsTotal; i0 = iHsTotal; o0 = oHsTotal;
    issue_job(8'($urandom_range(1, 255)));
    for (int n = 0; n < 5; n++) begin
      @(negedge clk); #3;
      check("k0_res_valid_held", bus.res_valid, 1);
      check("k0_res_data_held", bus.res_data, 0);
    end
    check("k0_busy", bus.busy, 1);
    resHold = 0;
    wait_done(50);
    check("k0_w_hs", wHsTotal - w0, 0);
    check("k0_i_hs", iHsTotal - i0, 0);
    check("k0_o_hs", oHsTotal - o0, 0);

    // Accumulator wrap: 65025 + 65025 + 1020 = 0x1FFFE.
    jobW = '{8'd255, 8'd255, 8'd255};
    jobI = '{8'd255, 8'd255, 8'd4};
    issue_job(8'd0);
    wait_done(200);

    // Randomised jobs under random valid/ready/result timing, including a full K=255 job.
    rndRdy = 1; rndValid = 1; rndDelay = 1;
    for (int j = 0; j < 20; j++) begin
      make_job((j == 10) ? 255 : $urandom_range(0, 12));
      issue_job(8'($urandom));
      wait_done(5000);
    end
    rndRdy = 0; rndValid = 0; rndDelay = 0;
    check("random_err_clear", bus.err, 0);

    // Stray result while idle sets the sticky error; next job is unaffected.
    @(negedge clk); #3;
    stray = 1;
    repeat (3) @(negedge clk);
    #3;
    check("err_set_idle", bus.err, 1);
    make_job(2);
    issue_job(8'($urandom));
    wait_done(200);
    check("err_sticky", bus.err, 1);

    // Reset in the middle of a K=5 job.
    make_job(5);
    w0 = wHsTotal;
    issue_job(8'($urandom));
    for (int t = 0; wHsTotal - w0 < 2; t++) begin
      if (t > 100) begin fail_now("mid_job_progress"); break; end
      @(negedge clk); #3;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",      bus.busy, 0);
    check("mid_rst_err",       bus.err, 0);
    check("mid_rst_res_valid", bus.res_valid, 0);
    check("mid_rst_pe_w_valid", bus.pe_w_valid, 0);
    check("mid_rst_pe_i_valid", bus.pe_i_valid, 0);
    check("mid_rst_pe_o_nop",  bus.pe_o_nop, 0);
    check("mid_rst_src_i_rdy", bus.src_i_rdy, 0);
    check("mid_rst_res_data",  bus.res_data, 0);
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    expQ.delete();
    #1;
    check("post_rst_cmd_rdy", bus.cmd_rdy, 1);
    make_job(1);
    issue_job(8'($urandom));
    wait_done(200);
    check("post_rst_err", bus.err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
